// File: rtl/sum9_arbiter.sv
// Two-requester round-robin arbiter feeding one shared 9-bit sign-magnitude adder
// with a one-entry result register. Define SUM9_ARB_SAT_EN to saturate overflow.

module sum9_smadd (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] sum
);

  logic [8:0] magSum;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    sum    = '0;
    magSum = {1'b0, a[7:0]} + {1'b0, b[7:0]};
    if (a[8] == b[8]) begin
`ifdef SUM9_ARB_SAT_EN
      sum = {a[8], magSum[8] ? 8'hFF : magSum[7:0]};
`else
      sum = {a[8], magSum[7:0]};
`endif
    end else if (a[7:0] >= b[7:0]) begin
      // Equal magnitudes land here, so the result keeps the sign of a.
      sum = {a[8], a[7:0] - b[7:0]};
    end else begin
      sum = {b[8], b[7:0] - a[7:0]};
    end
  end

endmodule

module sum9_arbiter #(
  parameter bit INIT_PRIO = 1'b0,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [8:0]       req0_a,
  input  logic [8:0]       req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [8:0]       req1_a,
  input  logic [8:0]       req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [8:0]       rsp_sum,
  input  logic             rsp_ready,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  typedef enum logic {EMPTY, FULL} stateT;

  stateT      state;
  stateT      stateNext;
  logic       prio;
  logic       grantId;
  logic       anyValid;
  logic       slotFree;
  logic       accept;
  logic [8:0] selA;
  logic [8:0] selB;
  logic [8:0] addSum;

  // With both requesters valid the pointer decides; otherwise the lone valid side wins.
  assign anyValid = req0_valid || req1_valid;
  assign grantId  = req1_valid && (!req0_valid || prio);
  assign slotFree = (state == EMPTY) || rsp_ready;
  assign selA     = grantId ? req1_a : req0_a;
  assign selB     = grantId ? req1_b : req0_b;

  sum9_smadd u_add (
    .a   (selA),
    .b   (selB),
    .sum (addSum)
  );

  always_comb begin
    stateNext  = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    if (!reset && slotFree && anyValid) begin
      req0_ready = !grantId;
      req1_ready = grantId;
      accept     = 1'b1;
    end
    if (accept) begin
      stateNext = FULL;
    end else if (state == FULL && rsp_ready) begin
      stateNext = EMPTY;
    end
  end

  assign rsp_valid = (state == FULL);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      prio     <= INIT_PRIO;
      rsp_id   <= 1'b0;
      rsp_sum  <= '0;
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        prio    <= !grantId;
        rsp_id  <= grantId;
        rsp_sum <= addSum;
        if (grantId) gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
        else         gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sum9_arbiter.sv
// Directed bench for sum9_arbiter: stimulus pushes expected results into a queue and
// a negedge monitor pops and compares them on every response transfer.

module tb_sum9_arbiter;

  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             req0_valid = 1'b0;
  logic [8:0]       req0_a = '0;
  logic [8:0]       req0_b = '0;
  logic             req0_ready;
  logic             req1_valid = 1'b0;
  logic [8:0]       req1_a = '0;
  logic [8:0]       req1_b = '0;
  logic             req1_ready;
  logic             rsp_valid;
  logic             rsp_id;
  logic [8:0]       rsp_sum;
  logic             rsp_ready = 1'b0;
  logic [CNT_W-1:0] gnt_cnt0;
  logic [CNT_W-1:0] gnt_cnt1;

  int total = 0;
  int bad   = 0;
  logic [9:0] expQ[$];

`ifdef SUM9_ARB_SAT_EN
  localparam logic [8:0] OVF_SUM = 9'h0FF;
`else
  localparam logic [8:0] OVF_SUM = 9'h02C;
`endif

  sum9_arbiter #(.INIT_PRIO(1'b0), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_sum    (rsp_sum),
    .rsp_ready  (rsp_ready),
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle; expGnt -1 means no acceptance, else the granted requester.
  task automatic issue(input string name, input logic rst,
                       input logic v0, input logic [8:0] a0, input logic [8:0] b0,
                       input logic v1, input logic [8:0] a1, input logic [8:0] b1,
                       input logic rr, input int expGnt, input logic [8:0] expSum);
    logic [1:0] expRdy;
    @(posedge clk);
    #1;
    reset      = rst;
    req0_valid = v0;
    req0_a     = a0;
    req0_b     = b0;
    req1_valid = v1;
    req1_a     = a1;
    req1_b     = b1;
    rsp_ready  = rr;
    if (rst) expQ.delete();
    @(negedge clk);
    expRdy = (expGnt == 0) ? 2'b01 : (expGnt == 1) ? 2'b10 : 2'b00;
    check({name, "_ready"}, {30'd0, req1_ready, req0_ready}, {30'd0, expRdy});
    if (expGnt >= 0) expQ.push_back({expGnt[0], expSum});
  endtask

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (expQ.size() == 0) begin
        check("rsp_unexpected", {22'd0, rsp_id, rsp_sum}, 32'hFFFF_FFFF);
      end else begin
        check("rsp_data", {22'd0, rsp_id, rsp_sum}, {22'd0, expQ.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset cycles: readies must stay low even with a request pending.
    issue("rst0", 1'b1, 1'b1, 9'h001, 9'h001, 1'b1, 9'h001, 9'h001, 1'b1, -1, 9'h000);
    issue("rst1", 1'b1, 1'b1, 9'h001, 9'h001, 1'b0, 9'h000, 9'h000, 1'b1, -1, 9'h000);

    // Both valid for four cycles: strict alternation starting from requester 0.
    issue("rr0", 1'b0, 1'b1, 9'h00A, 9'h014, 1'b1, 9'h132, 9'h014, 1'b1, 0, 9'h01E);
    check("post_reset_valid", {31'd0, rsp_valid}, 32'd0);
    check("post_reset_cnt", {26'd0, gnt_cnt1, gnt_cnt0}, 32'd0);
    check("post_reset_sum", {22'd0, rsp_id, rsp_sum}, 32'd0);
    issue("rr1", 1'b0, 1'b1, 9'h00A, 9'h014, 1'b1, 9'h132, 9'h014, 1'b1, 1, 9'h11E);
    issue("rr2", 1'b0, 1'b1, 9'h00A, 9'h014, 1'b1, 9'h132, 9'h014, 1'b1, 0, 9'h01E);
    issue("rr3", 1'b0, 1'b1, 9'h00A, 9'h014, 1'b1, 9'h132, 9'h014, 1'b1, 1, 9'h11E);

    // Mixed signs, equal-magnitude cancellation, same-sign overflow.
    issue("plus5_minus3", 1'b0, 1'b1, 9'h005, 9'h103, 1'b0, 9'h000, 9'h000, 1'b1, 0, 9'h002);
    check("rr_counts", {26'd0, gnt_cnt1, gnt_cnt0}, {26'd0, 3'd2, 3'd2});
    issue("minus7_plus7", 1'b0, 1'b1, 9'h107, 9'h007, 1'b0, 9'h000, 9'h000, 1'b1, 0, 9'h100);
    issue("overflow", 1'b0, 1'b0, 9'h000, 9'h000, 1'b1, 9'h0C8, 9'h064, 1'b1, 1, OVF_SUM);

    // Backpressure: hold the result, then drain and accept in the same cycle.
    issue("hold_acc", 1'b0, 1'b1, 9'h064, 9'h101, 1'b1, 9'h164, 9'h001, 1'b1, 0, 9'h063);
    issue("hold_a", 1'b0, 1'b1, 9'h064, 9'h101, 1'b1, 9'h164, 9'h001, 1'b0, -1, 9'h000);
    check("hold_a_sum", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 1'b0, 9'h063});
    issue("hold_b", 1'b0, 1'b0, 9'h064, 9'h101, 1'b1, 9'h164, 9'h001, 1'b0, -1, 9'h000);
    check("hold_b_sum", {21'd0, rsp_valid, rsp_id, rsp_sum}, {21'd0, 1'b1, 1'b0, 9'h063});
    issue("drain_acc", 1'b0, 1'b1, 9'h064, 9'h101, 1'b1, 9'h164, 9'h001, 1'b1, 1, 9'h163);
    issue("idle0", 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 9'h000, 9'h000, 1'b1, -1, 9'h000);
    check("mid_counts", {26'd0, gnt_cnt1, gnt_cnt0}, {26'd0, 3'd4, 3'd5});

    // Three more requester-0 grants wrap its 3-bit counter from 7 back to 0.
    for (int i = 0; i < 3; i++) begin
      issue("wrap", 1'b0, 1'b1, 9'h001, 9'h001, 1'b0, 9'h000, 9'h000, 1'b1, 0, 9'h002);
    end
    issue("idle1", 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 9'h000, 9'h000, 1'b1, -1, 9'h000);
    check("wrap_counts", {26'd0, gnt_cnt1, gnt_cnt0}, {26'd0, 3'd4, 3'd0});

    // Reset while FULL discards the result; prio returns to requester 0.
    issue("pre_rst", 1'b0, 1'b1, 9'h001, 9'h001, 1'b0, 9'h000, 9'h000, 1'b1, 0, 9'h002);
    issue("full_rst", 1'b1, 1'b1, 9'h001, 9'h001, 1'b1, 9'h001, 9'h001, 1'b0, -1, 9'h000);
    issue("after_rst", 1'b0, 1'b1, 9'h00A, 9'h014, 1'b1, 9'h132, 9'h014, 1'b1, 0, 9'h01E);
    check("after_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("after_rst_cnt", {26'd0, gnt_cnt1, gnt_cnt0}, 32'd0);
    issue("idle2", 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 9'h000, 9'h000, 1'b1, -1, 9'h000);
    check("final_cnt", {26'd0, gnt_cnt1, gnt_cnt0}, {26'd0, 3'd0, 3'd1});
    issue("idle3", 1'b0, 1'b0, 9'h000, 9'h000, 1'b0, 9'h000, 9'h000, 1'b1, -1, 9'h000);
    check("queue_empty", expQ.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sum9_arbiter.md
SUM9_ARBITER -- requirements
Module: sum9_arbiter

Interface
REQ-001 The block SHALL have parameter INIT_PRIO, default 0: the requester holding priority after reset (0 or 1).
REQ-002 The block SHALL have parameter CNT_W, default 16: width of the per-requester grant counters.
REQ-003 Port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Ports req0_valid / req1_valid  input  1  requester n presents an operand pair.
REQ-006 Ports req0_a, req0_b / req1_a, req1_b  input  9 each  sign-magnitude operands: bit 8 is the sign, bits 7:0 the magnitude.
REQ-007 Ports req0_ready / req1_ready  output  1  requester n's pair is accepted this cycle.
REQ-008 Port rsp_valid  output  1  the result register holds a result.
REQ-009 Port rsp_id  output  1  index of the requester that owns the result.
REQ-010 Port rsp_sum  output  9  sign-magnitude sum.
REQ-011 Port rsp_ready  input  1  the consumer takes the result this cycle.
REQ-012 Ports gnt_cnt0 / gnt_cnt1  output  CNT_W each  accepted-request counts.

Function
REQ-013 A transfer on side n SHALL occur when reqn_valid and reqn_ready are both high; a response transfer SHALL occur when rsp_valid and rsp_ready are both high.
REQ-014 reqn_ready SHALL be combinational and SHALL be high only when the requester is granted and the slot is free, where free = (!rsp_valid || rsp_ready).
REQ-015 Grant rule: with one valid requester, that requester is granted; with both valid, the requester named by the priority pointer prio is granted.
REQ-016 After every accepted request, prio SHALL become the index of the requester that was not granted (round-robin); with no acceptance, prio SHALL hold.
REQ-017 At most one request SHALL be accepted per cycle.
REQ-018 The block SHALL instantiate one shared sign-magnitude adder. With equal signs, magnitudes add and the common sign is kept. With differing signs, the smaller magnitude is subtracted from the larger and the larger operand's sign is kept; on equal magnitudes the sign of a is kept.
REQ-019 Latency SHALL be 1 cycle: on acceptance, rsp_sum, rsp_id and rsp_valid=1 are registered and visible the next cycle.
REQ-020 Output state machine: EMPTY (rsp_valid=0) and FULL (rsp_valid=1). EMPTY->FULL on accept. FULL->EMPTY on a response transfer with no accept. FULL->FULL with the new data on a simultaneous response transfer and accept (full throughput, one result per cycle).
REQ-021 In FULL with rsp_ready=0, rsp_sum and rsp_id SHALL hold stable and both readies SHALL be low.
REQ-022 A requester SHALL not be starved: when both requesters are continuously valid and rsp_ready=1, grants SHALL alternate every cycle.
REQ-023 gnt_cntn SHALL increment by 1 on each transfer on side n and SHALL wrap from 2^CNT_W-1 to 0.
REQ-024 Deasserting reqn_valid without a transfer SHALL not change prio or the counters.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL set rsp_valid=0, rsp_id=0, rsp_sum=0, gnt_cnt0=gnt_cnt1=0 and prio=INIT_PRIO.
REQ-026 During a cycle with reset high, req0_ready and req1_ready SHALL be low, and no transfer SHALL be counted.
REQ-027 Reset asserted while FULL SHALL discard the pending result with no response.

Configuration
REQ-028 The macro SUM9_ARB_SAT_EN SHALL control magnitude overflow on same-sign addition (sum > 255).
REQ-029 With SUM9_ARB_SAT_EN defined, the magnitude SHALL saturate to 255 and the sign SHALL be kept.
REQ-030 Without SUM9_ARB_SAT_EN, the magnitude SHALL wrap modulo 256 and the sign SHALL be kept.

Verification
REQ-031 A single req0 of a=0_00000101 (+5) and b=1_00000011 (-3) -> next cycle rsp_valid=1, rsp_id=0, rsp_sum=0_00000010.
REQ-032 Both requesters valid for 4 cycles with rsp_ready=1 and INIT_PRIO=0 -> grant order 0,1,0,1 and gnt_cnt0=gnt_cnt1=2.
REQ-033 rsp_ready=0 with a result held and both requests pending -> readies stay low and rsp_sum stays stable; rsp_ready=1 -> drain and a new accept occur in the same cycle.
REQ-034 req1 of a=0_11001000 (+200) and b=0_01100100 (+100) -> rsp_sum=0_11111111 with SUM9_ARB_SAT_EN; 0_00101100 (+44) without.
REQ-035 req0 of a=1_00000111 (-7) and b=0_00000111 (+7) -> rsp_sum=1_00000000.
REQ-036 Reset pulsed while FULL -> next cycle rsp_valid=0, counters=0 and prio=INIT_PRIO.
